// File: rtl/e_rx_block_buffer_if.sv
// Byte-in / word-out handshake bundle of the SDIO receive block buffer.
// The master side is the deserialiser plus host bus; the slave side is the buffer.
interface e_rx_block_buffer_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 2,
    parameter int DEPTH = 1024
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic [11:0]      block_size;
    logic             push;
    logic [IN_W-1:0]  push_data;
    logic             dat_end;
    logic             buffer_write_rdy;
    logic             pop;
    logic [OUT_W-1:0] pop_data;
    logic             buffer_read_en;
    logic             empty;
    logic             almost_full;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output block_size, push, push_data, dat_end, pop, clr_err,
        input  buffer_write_rdy, pop_data, buffer_read_en, empty, almost_full,
               level, overflow, underflow
    );

    modport slave (
        input  block_size, push, push_data, dat_end, pop, clr_err,
        output buffer_write_rdy, pop_data, buffer_read_en, empty, almost_full,
               level, overflow, underflow
    );
endinterface

// File: rtl/e_rx_block_buffer.sv
// SDIO receive block buffer: packs bytes LSB-first into words, zero-pads the
// tail of a block, then holds the block for readout and self-flushes.
module e_rx_block_buffer #(
    parameter int IN_W     = 8,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 1024,
    parameter int AFULL_TH = DEPTH - 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    e_rx_block_buffer_if.slave   bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RS    = $clog2(RATIO);

    typedef enum logic [1:0] {FILL, PAD, DRAIN} state_e;

    state_e           state_q;
    logic [PW-1:0]    pk_cnt_q;
    logic [OUT_W-1:0] pack_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic [12:0]      pop_cnt_q, bytes_q;
    logic             started_q, wr_rdy_q, rd_en_q, ovf_q, unf_q;
    logic [OUT_W-1:0] mem [DEPTH];

    logic             word_done, full, fill_push, store_ok, pop_ok, flush;
    logic             ovf_set, unf_set;
    logic [PW-1:0]    pk_post;
    logic [12:0]      exp_words;
    logic [IN_W-1:0]  in_byte;
    logic [OUT_W-1:0] pack_word;

    assign word_done = (pk_cnt_q == PW'(RATIO - 1));
    assign full      = (level_q == (AW + 1)'(DEPTH));
    assign fill_push = (state_q == FILL) && bus.push;
    // PAD feeds one zero byte per cycle through the same lane path as real data.
    assign in_byte   = (state_q == PAD) ? '0 : bus.push_data;
    assign store_ok  = (fill_push || state_q == PAD) && !(word_done && full);
    assign pk_post   = word_done ? '0 : pk_cnt_q + PW'(1);

    assign pop_ok    = (state_q == DRAIN) && bus.pop && (level_q != '0);
    assign exp_words = 13'((14'(bytes_q) + 14'(RATIO - 1)) >> RS);
    assign flush     = pop_ok && ((pop_cnt_q == exp_words - 13'd1) ||
                                  (level_q == (AW + 1)'(1)));

    assign ovf_set   = (bus.push && (state_q != FILL || (word_done && full))) ||
                       (state_q == PAD && word_done && full);
    assign unf_set   = bus.pop && !pop_ok;

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        pack_word = pack_q;
        pack_word[int'(pk_cnt_q) * IN_W +: IN_W] = in_byte;
    end

    // NOTE: storage carries no reset; level and the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (store_ok && word_done) mem[wr_ptr_q] <= pack_word;
    end

    // NOTE: all state updates use non-blocking assignments; later ones in the block win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            pk_cnt_q  <= '0;
            pack_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pop_cnt_q <= '0;
            bytes_q   <= '0;
            started_q <= 1'b0;
            wr_rdy_q  <= 1'b1;
            rd_en_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            ovf_q <= ovf_set || (ovf_q && !bus.clr_err);
            unf_q <= unf_set || (unf_q && !bus.clr_err);

            if (store_ok) begin
                pack_q   <= pack_word;
                pk_cnt_q <= pk_post;
                if (word_done) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    level_q  <= level_q + (AW + 1)'(1);
                end
            end
            // Block length is captured once, on the first byte actually stored.
            if (fill_push && store_ok && !started_q) begin
                bytes_q   <= {(bus.block_size == 12'd0), bus.block_size};
                started_q <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                pop_cnt_q <= pop_cnt_q + 13'd1;
                level_q   <= level_q - (AW + 1)'(1);
            end

            case (state_q)
                FILL: if (bus.dat_end) begin
                    wr_rdy_q <= 1'b0;
                    if ((store_ok ? pk_post : pk_cnt_q) != '0) begin
                        state_q <= PAD;
                    end else begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b1;
                    end
                end
                PAD: if (word_done) begin
                    state_q  <= DRAIN;
                    rd_en_q  <= 1'b1;
                    pk_cnt_q <= '0;
                end
                DRAIN: if (flush) begin
                    state_q   <= FILL;
                    wr_rdy_q  <= 1'b1;
                    rd_en_q   <= 1'b0;
                    wr_ptr_q  <= '0;
                    rd_ptr_q  <= '0;
                    pk_cnt_q  <= '0;
                    pop_cnt_q <= '0;
                    level_q   <= '0;
                    started_q <= 1'b0;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.buffer_write_rdy = wr_rdy_q;
    assign bus.buffer_read_en   = rd_en_q;
    assign bus.empty            = (level_q == '0);
    assign bus.almost_full      = (level_q >= (AW + 1)'(AFULL_TH));
    assign bus.level            = level_q;
    assign bus.overflow         = ovf_q;
    assign bus.underflow        = unf_q;
    assign bus.pop_data         = (level_q == '0) ? '0 : mem[rd_ptr_q];
endmodule

// File: tb/tb_e_rx_block_buffer.sv
// Scoreboard bench for e_rx_block_buffer: blocks are modelled as byte lists,
// expected words are queued at stimulus time and popped by a monitor.
module tb_e_rx_block_buffer;
    localparam int IN_W     = 8;
    localparam int RATIO    = 2;
    localparam int DEPTH    = 2048;
    localparam int AFULL_TH = DEPTH - 4;
    localparam int OUT_W    = IN_W * RATIO;
    localparam int R4       = 4;
    localparam int DEPTH4   = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    e_rx_block_buffer_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH))  bus ();
    e_rx_block_buffer_if #(.IN_W(IN_W), .RATIO(R4),    .DEPTH(DEPTH4)) bus4 ();

    e_rx_block_buffer #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    e_rx_block_buffer #(.IN_W(IN_W), .RATIO(R4), .DEPTH(DEPTH4), .AFULL_TH(DEPTH4 - 4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [OUT_W-1:0]  exp_q[$];
    logic [4*IN_W-1:0] exp4_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Monitor: every word the DUT hands over is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.pop && bus.buffer_read_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_data: word 0x%0h popped, none expected at %0t", bus.pop_data, $time);
            end else begin
                check("pop_data", 64'(bus.pop_data), 64'(exp_q.pop_front()));
            end
        end
        if (rst_n && bus4.pop && bus4.buffer_read_en && !bus4.empty) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL r4_pop_data: word 0x%0h popped, none expected at %0t", bus4.pop_data, $time);
            end else begin
                check("r4_pop_data", 64'(bus4.pop_data), 64'(exp4_q.pop_front()));
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_write_rdy"}, 64'(bus.buffer_write_rdy), 64'd1);
        check({tag, "_read_en"},   64'(bus.buffer_read_en),   64'd0);
        check({tag, "_empty"},     64'(bus.empty),            64'd1);
        check({tag, "_afull"},     64'(bus.almost_full),      64'd0);
        check({tag, "_level"},     64'(bus.level),            64'd0);
        check({tag, "_overflow"},  64'(bus.overflow),         64'd0);
        check({tag, "_underflow"}, 64'(bus.underflow),        64'd0);
        check({tag, "_pop_data"},  64'(bus.pop_data),         64'd0);
    endtask

    // One block through the RATIO=2 instance. Bytes: random when stride==0,
    // otherwise base + i*stride. Expected words follow directly from the rules:
    // stored = ceil(n/RATIO), readable = min(ceil(bytes/RATIO), stored).
    task automatic do_block(input int bs, input int n, input int base, input int stride,
                            input bit gaps, input bit drain_push, input bit full_extra);
        logic [IN_W-1:0]  bytes[$];
        logic [OUT_W-1:0] word;
        int eb, w, e, m, pend, lat, cyc, popped, idx;
        bit end_sent;
        eb = (bs == 0) ? 4096 : bs;
        for (int i = 0; i < n; i++)
            bytes.push_back((stride == 0) ? IN_W'($urandom) : IN_W'(base + i * stride));
        w = ceil_div(n, RATIO);
        e = ceil_div(eb, RATIO);
        m = (e < w) ? e : w;
        for (int k = 0; k < m; k++) begin
            word = '0;
            for (int j = 0; j < RATIO; j++) begin
                idx = k * RATIO + j;
                if (idx < n) word[j*IN_W +: IN_W] = bytes[idx];
            end
            exp_q.push_back(word);
        end

        bus.block_size = 12'(bs);
        end_sent = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) while ($urandom_range(3) == 0) begin bus.push = 1'b0; step(); end
            bus.push      = 1'b1;
            bus.push_data = bytes[i];
            if (i == n - 1 && gaps && $urandom_range(1) == 1) begin
                bus.dat_end = 1'b1;
                end_sent    = 1'b1;
            end
            step();
            bus.push    = 1'b0;
            bus.dat_end = 1'b0;
            check("level_fill", 64'(bus.level), 64'((i + 1) / RATIO));
            check("almost_full", 64'(bus.almost_full), 64'(((i + 1) / RATIO) >= AFULL_TH));
        end
        if (full_extra) begin
            for (int j = 0; j < RATIO; j++) begin
                bus.push = 1'b1; bus.push_data = 8'hEE; step();
            end
            bus.push = 1'b0;
            check("overflow_at_full", 64'(bus.overflow), 64'd1);
            check("level_at_full", 64'(bus.level), 64'(DEPTH));
        end

        pend = (n + (full_extra ? RATIO - 1 : 0)) % RATIO;
        lat  = 1 + ((pend != 0) ? RATIO - pend : 0);
        if (!end_sent) begin bus.dat_end = 1'b1; step(); bus.dat_end = 1'b0; end
        cyc = 1;
        while (!bus.buffer_read_en && cyc < lat + 8) begin step(); cyc++; end
        check("read_en_latency", 64'(cyc), 64'(lat));
        check("write_rdy_drain", 64'(bus.buffer_write_rdy), 64'd0);
        check("level_drain", 64'(bus.level), 64'(w));

        if (drain_push) begin
            bus.push = 1'b1; bus.push_data = 8'h5A; step(); bus.push = 1'b0;
            check("overflow_drain_push", 64'(bus.overflow), 64'd1);
            check("level_drain_push", 64'(bus.level), 64'(w));
            bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
            check("overflow_cleared", 64'(bus.overflow), 64'd0);
        end

        popped = 0;
        cyc    = 0;
        while (popped < m && cyc < 4 * m + 20) begin
            bus.pop = gaps ? ($urandom_range(3) != 0) : 1'b1;
            step();
            if (bus.pop) popped++;
            cyc++;
        end
        bus.pop = 1'b0;
        check("pops_done", 64'(popped), 64'(m));
        check("flush_read_en", 64'(bus.buffer_read_en), 64'd0);
        check("flush_write_rdy", 64'(bus.buffer_write_rdy), 64'd1);
        check("flush_level", 64'(bus.level), 64'd0);
        check("flush_empty", 64'(bus.empty), 64'd1);
        check("no_underflow", 64'(bus.underflow), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        check("flags_cleared", 64'({bus.overflow, bus.underflow}), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bs, n, mode, cyc;
        bus.block_size = '0;  bus.push = 1'b0;  bus.push_data = '0;
        bus.dat_end = 1'b0;   bus.pop = 1'b0;   bus.clr_err = 1'b0;
        bus4.block_size = '0; bus4.push = 1'b0; bus4.push_data = '0;
        bus4.dat_end = 1'b0;  bus4.pop = 1'b0;  bus4.clr_err = 1'b0;

        #12;
        check_reset("reset");
        check("r4_reset_write_rdy", 64'(bus4.buffer_write_rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic packing: 0x11,0x22,0x33,0x44 -> 0x2211, 0x4433.
        do_block(4, 4, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0);

        // Pop in FILL, then clear racing a new error, then a clean clear.
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        check("underflow_pop_fill", 64'(bus.underflow), 64'd1);
        bus.pop = 1'b1; bus.clr_err = 1'b1; step(); bus.pop = 1'b0; bus.clr_err = 1'b0;
        check("underflow_error_wins", 64'(bus.underflow), 64'd1);
        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        check("underflow_cleared", 64'(bus.underflow), 64'd0);

        do_block(8, 4, 0, 0, 1'b0, 1'b0, 1'b0);   // short block: flush on last stored word
        do_block(4, 5, 0, 0, 1'b0, 1'b0, 1'b0);   // excess byte discarded by flush
        do_block(5, 5, 0, 0, 1'b0, 1'b0, 1'b0);   // padded tail
        do_block(6, 6, 0, 0, 1'b0, 1'b1, 1'b0);   // push during DRAIN

        for (int it = 0; it < 40; it++) begin
            bs   = $urandom_range(24, 1);
            mode = $urandom_range(2);
            n    = (mode == 0) ? bs : (mode == 1) ? $urandom_range(bs, 1) : bs + $urandom_range(3, 1);
            do_block(bs, n, 0, 0, 1'b1, ($urandom_range(3) == 0), 1'b0);
        end

        // Full 4096-byte blocks, the first one overrun at full level.
        do_block(0, 4096, 0, 1, 1'b0, 1'b0, 1'b1);
        do_block(0, 4096, 0, 1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of DRAIN after one pop.
        bus.block_size = 12'd4;
        exp_q.push_back(16'h5150);
        exp_q.push_back(16'h5352);
        for (int i = 0; i < 4; i++) begin
            bus.push = 1'b1; bus.push_data = 8'(8'h50 + i); step();
        end
        bus.push = 1'b0;
        bus.dat_end = 1'b1; step(); bus.dat_end = 1'b0;
        check("mid_read_en", 64'(bus.buffer_read_en), 64'd1);
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_block(4, 4, 0, 0, 1'b0, 1'b0, 1'b0);

        // RATIO=4 padding: 5 bytes -> 0xA3A2A1A0, 0x000000A4, read_en 4 cycles after dat_end.
        bus4.block_size = 12'd5;
        exp4_q.push_back(32'hA3A2A1A0);
        exp4_q.push_back(32'h000000A4);
        for (int i = 0; i < 5; i++) begin
            bus4.push = 1'b1; bus4.push_data = 8'(8'hA0 + i); step();
        end
        bus4.push = 1'b0;
        bus4.dat_end = 1'b1; step(); bus4.dat_end = 1'b0;
        cyc = 1;
        while (!bus4.buffer_read_en && cyc < 12) begin step(); cyc++; end
        check("r4_read_en_latency", 64'(cyc), 64'd4);
        check("r4_level", 64'(bus4.level), 64'd2);
        bus4.pop = 1'b1; step(); step(); bus4.pop = 1'b0;
        check("r4_flush_read_en", 64'(bus4.buffer_read_en), 64'd0);
        check("r4_flush_write_rdy", 64'(bus4.buffer_write_rdy), 64'd1);
        check("r4_flush_empty", 64'(bus4.empty), 64'd1);
        check("r4_no_underflow", 64'(bus4.underflow), 64'd0);
        check("r4_scoreboard_drained", 64'(exp4_q.size()), 64'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
